seqdet_scheduler: RTL and testbench
===================================

# seqdet_scheduler

Round-robin scheduler that shares one serial sequence-detector instance (ports `x`, `clk`, `reset`, `y`) among `N_REQ` requesters. Each requester presents a parallel frame. The scheduler clears the detector, shifts the frame MSB-first onto the detector's `x`, counts the `y` hits, and returns a per-frame hit count tagged with the requester id. It sits between the requesting blocks and the single detector datapath.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `FRAME_LEN`, 8: bits per frame, 2..32.
- `DET_LAT`, 1: cycles from a bit driven on `det_x` to its `det_y` response, 1..4.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, N_REQ: request per requester. Held until that requester's `done`.
- `frame_data`, in, N_REQ*FRAME_LEN: requester i occupies slice `[i*FRAME_LEN +: FRAME_LEN]`. Stable while `req[i]`=1.
- `gnt`, out, N_REQ: one-hot grant; all zero when no frame is active.
- `det_x`, out, 1: serial bit to the detector.
- `det_reset`, out, 1: detector reset; equals `reset` OR (state==CLEAR).
- `det_y`, in, 1: detector output.
- `done`, out, 1: one-cycle pulse when a frame completes.
- `done_id`, out, $clog2(N_REQ): id of the completed requester; held until the next `done`.
- `hit_count`, out, $clog2(FRAME_LEN+1): hits in the completed frame; held until the next `done`.

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - If any `req` is set, the round-robin arbiter picks the first set requester searching from `last_id+1` (wrapping). After reset the search starts at id 0.
  - Latch the id, load the frame into the shift register, go to CLEAR.
- CLEAR (1 cycle): `gnt` asserted, `det_reset`=1, `det_x`=0, hit counter cleared.
- SHIFT (FRAME_LEN cycles): `det_x` = frame bit FRAME_LEN-1-k in SHIFT cycle k.
- DRAIN (DET_LAT cycles): `det_x`=0.
- Hit sampling: `det_y` is sampled in SHIFT cycles k ≥ DET_LAT and in every DRAIN cycle, giving exactly FRAME_LEN samples. Each sample of 1 increments the counter; the counter saturates at FRAME_LEN.
- DONE (1 cycle): `done`=1; `done_id` and `hit_count` update; `gnt` returns to 0; `last_id` is updated; next state is IDLE.
- Abort: if `req[id]` drops during CLEAR, SHIFT or DRAIN, go to IDLE next cycle. `gnt` goes to 0, there is no `done`, `last_id` still advances, and held outputs are unchanged.
- Requests arriving while a frame is active wait. Arbitration happens only in IDLE.
- Reset mid-frame: the next state is IDLE and all outputs take their reset values. `det_reset` is high during the reset cycle.

## Timing
- Reset values: `gnt`=0, `det_x`=0, `done`=0, `done_id`=0, `hit_count`=0, state=IDLE, `last_id`=N_REQ-1.
- `gnt` rises the cycle after the IDLE edge that samples `req`.
- `done` is high in the cycle that begins 1+FRAME_LEN+DET_LAT+1 edges after the sampling edge. With defaults this is 11 edges.
- Back-to-back throughput: one frame per FRAME_LEN+DET_LAT+3 cycles, since IDLE costs a 1-cycle bubble.
- `det_x` and `gnt` are registered outputs. `det_reset` is combinational from `reset` and the state register.

## Structure
- Shared package `seqdet_pkg`:
  - state enum {IDLE, CLEAR, SHIFT, DRAIN, DONE};
  - default parameter constants;
  - width helper for the id and count widths.
- Sub-module `rr_arbiter`: `req`, `last_id` → one-hot grant plus encoded id; combinational, N_REQ-parameterized.
- The top level holds the FSM, bit counter, shift register and hit counter.

## Test plan
The bench detector model is an echo (`y` = `x` registered once, so DET_LAT=1, and `y` clears on reset); with it, the hit count equals popcount(frame).
- Single frame: `req`=4'b0001, frame0=8'hA6 → `det_x` shows 1,0,1,0,0,1,1,0; `done` arrives 11 edges after sampling with `done_id`=0 and `hit_count`=4.
- Round-robin: `req`=4'b1011 held, all frames 8'hFF → `done_id` sequence 0,1,3,0; every `hit_count`=8; `done` pulses 11 cycles apart.
- Zero and full frames: frame 8'h00 → `hit_count`=0; frame 8'hFF → `hit_count`=8 (saturation boundary).
- Abort: drop `req[2]` in SHIFT cycle 3 → no `done`, `gnt`=0 next cycle, previous `done_id` and `hit_count` unchanged, next grant goes to id 3 if requested.
- Reset mid-frame: assert `reset` in SHIFT cycle 5 → next cycle all outputs are at reset values, `det_reset`=1 during reset, and after release a new request restarts from CLEAR with a correct count.

Source files
------------

// File: rtl/seqdet_pkg.sv
// Shared constants, FSM encodings and width helper for the sequence-detector scheduler.
package seqdet_pkg;

  localparam int unsigned N_REQ_DEF     = 4;
  localparam int unsigned FRAME_LEN_DEF = 8;
  localparam int unsigned DET_LAT_DEF   = 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  // Bits needed to encode values 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seqdet_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching from last_id+1, wrapping.
module rr_arbiter
  import seqdet_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = width_of(N_REQ_DEF)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last_id,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_id,
  output logic             o_valid
);

  int w_idx;

  // Walk from the farthest candidate to the nearest so the nearest set request wins.
  always_comb begin
    o_gnt   = '0;
    o_id    = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    for (int off = int'(N_REQ); off >= 1; off--) begin
      w_idx = (int'(i_last_id) + off) % int'(N_REQ);
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx[ID_W-1:0];
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seqdet_scheduler.sv
// Shares one serial sequence detector among N_REQ requesters: clear, shift a frame MSB-first,
// count detector hits, report the count tagged with the requester id.
//   state | meaning
//   IDLE  | arbitrate among pending requests, latch id and frame
//   CLEAR | detector held in reset, hit counter cleared
//   SHIFT | one frame bit per cycle on det_x, MSB first
//   DRAIN | det_x=0 while the last responses come back
//   DONE  | done pulse, results published, back to IDLE
module seqdet_scheduler
  import seqdet_pkg::*;
#(
  parameter int unsigned N_REQ     = N_REQ_DEF,
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned DET_LAT   = DET_LAT_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [N_REQ-1:0]                      req,
  input  logic [N_REQ*FRAME_LEN-1:0]            frame_data,
  output logic [N_REQ-1:0]                      gnt,
  output logic                                  det_x,
  output logic                                  det_reset,
  input  logic                                  det_y,
  output logic                                  done,
  output logic [width_of(N_REQ)-1:0]            done_id,
  output logic [width_of(FRAME_LEN+1)-1:0]      hit_count
);

  localparam int unsigned ID_W  = width_of(N_REQ);
  localparam int unsigned CNT_W = width_of(FRAME_LEN + 1);
  localparam int unsigned TMR_W = width_of(FRAME_LEN + DET_LAT);
  // SHIFT cycle k maps to timer value FRAME_LEN-1-k; sampling starts at k = DET_LAT.
  localparam int          SAMPLE_LIM = int'(FRAME_LEN) - int'(DET_LAT);

  state_t                 r_state;
  logic [ID_W-1:0]        r_id;
  logic [ID_W-1:0]        r_last_id;
  logic [FRAME_LEN-1:0]   r_shift;
  logic [TMR_W-1:0]       r_tmr;
  logic [CNT_W-1:0]       r_hits;
  logic [N_REQ-1:0]       r_gnt;
  logic                   r_det_x;
  logic                   r_done;
  logic [ID_W-1:0]        r_done_id;
  logic [CNT_W-1:0]       r_hit_count;

  logic [N_REQ-1:0]       w_arb_gnt;
  logic [ID_W-1:0]        w_arb_id;
  logic                   w_arb_valid;
  logic [FRAME_LEN-1:0]   w_frame;
  logic                   w_sample;
  logic                   w_abort;
  logic [CNT_W-1:0]       w_hits_nxt;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .i_req     (req),
    .i_last_id (r_last_id),
    .o_gnt     (w_arb_gnt),
    .o_id      (w_arb_id),
    .o_valid   (w_arb_valid)
  );

  assign w_frame  = frame_data[w_arb_id*FRAME_LEN +: FRAME_LEN];
  assign w_abort  = !req[r_id];
  assign w_sample = ((r_state == ST_SHIFT) && (int'(r_tmr) < SAMPLE_LIM)) ||
                    (r_state == ST_DRAIN);
  assign w_hits_nxt = (w_sample && det_y && (r_hits != CNT_W'(FRAME_LEN)))
                    ? r_hits + CNT_W'(1) : r_hits;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_id        <= '0;
      r_last_id   <= ID_W'(N_REQ - 1);
      r_shift     <= '0;
      r_tmr       <= '0;
      r_hits      <= '0;
      r_gnt       <= '0;
      r_det_x     <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= '0;
      r_hit_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_arb_valid) begin
            r_id    <= w_arb_id;
            r_shift <= w_frame;
            r_gnt   <= w_arb_gnt;
            r_det_x <= 1'b0;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR, ST_SHIFT, ST_DRAIN: begin
          if (w_abort) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_det_x   <= 1'b0;
            r_last_id <= r_id;
          end else if (r_state == ST_CLEAR) begin
            r_hits  <= '0;
            r_tmr   <= TMR_W'(FRAME_LEN - 1);
            r_det_x <= r_shift[FRAME_LEN-1];
            r_shift <= r_shift << 1;
            r_state <= ST_SHIFT;
          end else if (r_state == ST_SHIFT) begin
            r_hits <= w_hits_nxt;
            if (r_tmr == '0) begin
              r_det_x <= 1'b0;
              r_tmr   <= TMR_W'(DET_LAT - 1);
              r_state <= ST_DRAIN;
            end else begin
              r_det_x <= r_shift[FRAME_LEN-1];
              r_shift <= r_shift << 1;
              r_tmr   <= r_tmr - TMR_W'(1);
            end
          end else begin
            r_hits <= w_hits_nxt;
            if (r_tmr == '0) begin
              r_done      <= 1'b1;
              r_done_id   <= r_id;
              r_hit_count <= w_hits_nxt;
              r_gnt       <= '0;
              r_last_id   <= r_id;
              r_state     <= ST_DONE;
            end else begin
              r_tmr <= r_tmr - TMR_W'(1);
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign det_x     = r_det_x;
  assign det_reset = reset | (r_state == ST_CLEAR);
  assign done      = r_done;
  assign done_id   = r_done_id;
  assign hit_count = r_hit_count;

endmodule

// File: tb/tb_seqdet_scheduler.sv
// Directed bench for seqdet_scheduler with an echo detector (y = x delayed one cycle).
module tb_seqdet_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] frame_data;
  logic [3:0]  gnt;
  logic        det_x;
  logic        det_reset;
  logic        det_y;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  hit_count;

  int n_checks = 0;
  int n_errors = 0;

  seqdet_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .frame_data (frame_data),
    .gnt        (gnt),
    .det_x      (det_x),
    .det_reset  (det_reset),
    .det_y      (det_y),
    .done       (done),
    .done_id    (done_id),
    .hit_count  (hit_count)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (det_reset) det_y <= 1'b0;
    else           det_y <= det_x;
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] frames;
    int          exp_id;
    int          exp_hits;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Starts in IDLE, presents one request set, follows the frame to its done pulse, then drops req.
  task automatic run_frame(input logic [3:0] rq, input logic [31:0] fr,
                           input int eid, input int ehits, input string nm);
    logic [7:0] f;
    logic [7:0] seen;
    int         t;
    bit         got;
    req        = rq;
    frame_data = fr;
    f          = fr[eid*8 +: 8];
    seen       = '0;
    t          = 0;
    got        = 0;
    while (!got && t < 30) begin
      tick();
      t++;
      if (t == 1) chk({nm, "_gnt"}, {28'd0, gnt}, 32'(4'b0001 << eid));
      if (t >= 2 && t <= 9) seen[9 - t] = det_x;
      if (done) got = 1;
    end
    chk({nm, "_done_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      chk({nm, "_latency"}, t, 32'd11);
      chk({nm, "_done_id"}, {30'd0, done_id}, eid);
      chk({nm, "_hits"}, {28'd0, hit_count}, ehits);
      chk({nm, "_gnt_done"}, {28'd0, gnt}, 32'd0);
      chk({nm, "_det_x"}, {24'd0, seen}, {24'd0, f});
    end
    req = 4'b0000;
    tick();
  endtask

  vec_t vecs[6];

  initial begin
    int t;
    int n_done;
    int times[4];
    int ids[4];
    int hits[4];
    bit seen_done;

    vecs[0] = '{4'b0001, 32'h0000_00A6, 0, 4};
    vecs[1] = '{4'b0100, 32'h0000_0000, 2, 0};
    vecs[2] = '{4'b1000, 32'hFF00_0000, 3, 8};
    vecs[3] = '{4'b0110, 32'h003C_8100, 1, 2};
    vecs[4] = '{4'b0110, 32'h003C_8100, 2, 4};
    vecs[5] = '{4'b1001, 32'h0100_007F, 3, 1};

    reset      = 1'b1;
    req        = '0;
    frame_data = '0;
    tick();
    tick();
    chk("rst_gnt", {28'd0, gnt}, 0);
    chk("rst_det_x", {31'd0, det_x}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_done_id", {30'd0, done_id}, 0);
    chk("rst_hit_count", {28'd0, hit_count}, 0);
    chk("rst_det_reset", {31'd0, det_reset}, 1);
    reset = 1'b0;
    tick();
    chk("idle_det_reset", {31'd0, det_reset}, 0);

    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].req, vecs[i].frames, vecs[i].exp_id, vecs[i].exp_hits,
                $sformatf("vec%0d", i));

    // Round-robin with a held request set, starting from a fresh reset (last_id = 3).
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    req        = 4'b1011;
    frame_data = 32'hFFFF_FFFF;
    t      = 0;
    n_done = 0;
    while (n_done < 4 && t < 80) begin
      tick();
      t++;
      if (done) begin
        times[n_done] = t;
        ids[n_done]   = int'(done_id);
        hits[n_done]  = int'(hit_count);
        n_done++;
        if (n_done == 4) req = 4'b0000;
      end
    end
    chk("rr_count", n_done, 4);
    if (n_done == 4) begin
      chk("rr_first_lat", times[0], 11);
      chk("rr_id0", ids[0], 0);
      chk("rr_id1", ids[1], 1);
      chk("rr_id2", ids[2], 3);
      chk("rr_id3", ids[3], 0);
      for (int i = 0; i < 4; i++) chk($sformatf("rr_hits%0d", i), hits[i], 8);
      for (int i = 1; i < 4; i++) chk($sformatf("rr_gap%0d", i), times[i] - times[i-1], 12);
    end
    tick();

    // Abort: requester 2 drops in SHIFT cycle 3 while requester 3 starts asking.
    req        = 4'b0100;
    frame_data = 32'hFF5A_0000;
    seen_done  = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (done) seen_done = 1;
    end
    chk("abort_gnt_before", {28'd0, gnt}, 32'h4);
    req = 4'b1000;
    tick();
    if (done) seen_done = 1;
    chk("abort_no_done", {31'd0, seen_done}, 0);
    chk("abort_gnt_off", {28'd0, gnt}, 0);
    chk("abort_done_id_held", {30'd0, done_id}, 0);
    chk("abort_hits_held", {28'd0, hit_count}, 8);
    tick();
    chk("abort_next_gnt", {28'd0, gnt}, 32'h8);
    t = 7;
    while (!done && t < 40) begin
      tick();
      t++;
    end
    chk("abort_next_done_at", t, 17);
    chk("abort_next_id", {30'd0, done_id}, 3);
    chk("abort_next_hits", {28'd0, hit_count}, 8);
    req = 4'b0000;
    tick();

    // Reset in SHIFT cycle 5, then a restart with the request still held.
    req        = 4'b0001;
    frame_data = 32'h0000_00A6;
    for (int i = 1; i <= 7; i++) tick();
    reset = 1'b1;
    #1;
    chk("midrst_det_reset", {31'd0, det_reset}, 1);
    tick();
    chk("midrst_gnt", {28'd0, gnt}, 0);
    chk("midrst_det_x", {31'd0, det_x}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_done_id", {30'd0, done_id}, 0);
    chk("midrst_hit_count", {28'd0, hit_count}, 0);
    reset = 1'b0;
    run_frame(4'b0001, 32'h0000_00A6, 0, 4, "restart");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
